fb_output_arbiter: RTL
======================

Name: fb_output_arbiter

Overview:
- Round-robin wormhole arbiter for one router output port.
- Shares the port between NUM_IN input-buffer fifo instances; the buffer read side is zero-latency (data visible while not empty, pops on rd_en).
- Grants one input at a time and holds the grant from the head flit until the tail flit has been forwarded.
- Drives the downstream output-buffer fifo write port and honours its almost_full.

Parameters:
- NUM_IN, 4, number of competing input buffers (2..8, need not be a power of two).
- DATA_W, 8, flit width, bit order [0:DATA_W-1].
- TAIL_BIT, 0, index within the flit of the tail flag (1 = last flit of packet).

Ports:
- clk  in  1  clock, single domain.
- rst  in  1  synchronous, active-high reset.
- in_empty  in  NUM_IN  per-input buffer empty flag.
- in_req  in  NUM_IN  per-input flag: route of the flit at that buffer's head targets this output.
- in_data  in  NUM_IN*DATA_W  concatenated buffer heads; input i occupies bits [i*DATA_W : i*DATA_W+DATA_W-1].
- in_rd_en  out  NUM_IN  one-hot pop strobe to the granted buffer.
- out_almost_full  in  1  downstream buffer almost_full.
- out_wr_en  out  1  downstream write strobe.
- out_data  out  DATA_W  flit to downstream buffer.
- grant  out  NUM_IN  one-hot current owner; all zero when idle.
- busy  out  1  high while in LOCK.

Behaviour:
- Reset values: state IDLE, grant=0, rr_ptr=0, busy=0, in_rd_en=0, out_wr_en=0.
- out_data is driven from the in_data slice selected by grant, and is 0 when grant=0.
- Reset mid-packet drops the lock immediately; the remainder of the packet stays in its buffer.
- Input i is eligible when in_req[i] & ~in_empty[i].
- IDLE:
  - Search eligible inputs starting at rr_ptr, ascending with wrap modulo NUM_IN; first hit wins.
  - Winner's one-hot is registered into grant; state goes to LOCK next cycle.
  - Arbitration costs exactly 1 cycle; no flit moves in IDLE.
  - No eligible input: stay in IDLE.
- LOCK, transfer condition: fire = ~in_empty[g] & ~out_almost_full, where g is the granted input.
- LOCK, outputs (combinational, same cycle):
  - in_rd_en[g] = fire.
  - out_wr_en = fire.
  - out_data = in_data slice g.
  - Throughput is 1 flit/cycle while fire holds.
- LOCK, release:
  - On fire with flit[TAIL_BIT]=1: grant <= 0, rr_ptr <= (g+1) mod NUM_IN, state <= IDLE.
  - In the next cycle IDLE arbitrates again, so there is a 1-cycle bubble between packets.
- LOCK, stalls:
  - in_empty[g]=1 mid-packet: hold the lock, issue no strobes, wait indefinitely.
  - out_almost_full=1: hold the lock, issue no strobes. The last downstream slot is deliberately never used.
- in_req changes during LOCK are ignored; only the granted buffer's empty flag and tail flag matter.
- Single-flit packet (head with tail set): IDLE → LOCK → IDLE, 1 flit forwarded.
- Other inputs never see in_rd_en while a packet is locked, so there is no flit interleaving.
- Fairness: after releasing input g, g has the lowest priority. Each eligible input is served within NUM_IN-1 packets.
- Simultaneous tail release and new requests are resolved in the following IDLE cycle using the updated rr_ptr.

Optional Feature:
- Macro: FB_ARB_STATS_EN.
- When defined, adds two 16-bit outputs:
  - flit_cnt: counts cycles with fire=1.
  - stall_cnt: counts LOCK cycles with fire=0.
- Both counters saturate at 0xFFFF, reset to 0, and clear on rst only.
- When not defined, neither port nor logic exists, and behaviour is otherwise identical.

Test Plan:
- Single requester, NUM_IN=4: input 2 holds flits 0x11, 0x22, 0xA3 (tail in bit 0), downstream never almost_full. Required: grant=4'b0100 one cycle after eligibility; out_wr_en high 3 consecutive cycles with 0x11, 0x22, 0xA3; then IDLE; rr_ptr=3.
- All four inputs eligible from reset, each with a 2-flit packet. Required: service order 0,1,2,3; each packet 2 write cycles plus 1 arbitration cycle; 12 cycles total to drain.
- Backpressure: out_almost_full=1 for cycles 2-4 of a 4-flit packet. Required: no out_wr_en and no in_rd_en during those cycles; grant held; all 4 flits delivered in order; no flit from any other input interleaved.
- Source starvation: the granted buffer goes empty after its head flit while input 1 is eligible. Required: lock held, in_rd_en[1] never asserted until the tail arrives and is forwarded.
- Reset mid-packet: rst asserted during the second flit of a 3-flit packet. Required: next cycle grant=0, out_wr_en=0, busy=0; after rst release, arbitration restarts at input 0.
- FB_ARB_STATS_EN defined: run the backpressure case. Required: flit_cnt=4, stall_cnt=3; counters read 0 after rst.

Source files
------------

// File: rtl/fb_output_arbiter.sv
// Round-robin wormhole arbiter for one router output port: locks one input
// buffer from head to tail flit. Define FB_ARB_STATS_EN to add flit/stall counters.
module fb_output_arbiter #(
    parameter int NUM_IN   = 4,
    parameter int DATA_W   = 8,
    parameter int TAIL_BIT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IN-1:0]          in_empty,
    input  logic [NUM_IN-1:0]          in_req,
    input  logic [0:NUM_IN*DATA_W-1]   in_data,
    output logic [NUM_IN-1:0]          in_rd_en,
    input  logic                       out_almost_full,
    output logic                       out_wr_en,
    output logic [0:DATA_W-1]          out_data,
    output logic [NUM_IN-1:0]          grant,
    output logic                       busy
`ifdef FB_ARB_STATS_EN
   ,output logic [15:0]                flit_cnt,
    output logic [15:0]                stall_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_IN);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]                      state;
    logic [PTR_W-1:0]                rr_ptr;
    logic [PTR_W-1:0]                g_idx;
    logic [NUM_IN-1:0]               elig;
    logic [NUM_IN-1:0]               avail_v;
    logic [NUM_IN-1:0]               win_oh;
    logic [PTR_W-1:0]                win_idx;
    logic [PTR_W-1:0]                cand;
    logic                            win_found;
    logic                            fire;
    logic                            tail;
    logic [NUM_IN-1:0][0:DATA_W-1]   lane_data;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_IN) s = s - NUM_IN;
        return PTR_W'(s);
    endfunction

    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
        fb_output_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
            .gnt      (grant[i]),
            .req      (in_req[i]),
            .empty    (in_empty[i]),
            .fire     (fire),
            .data     (in_data[i*DATA_W +: DATA_W]),
            .elig     (elig[i]),
            .avail    (avail_v[i]),
            .rd_en    (in_rd_en[i]),
            .data_sel (lane_data[i])
        );
    end

    // grant is one-hot, so OR-ing the masked lanes is the slice mux
    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_IN; i++) out_data = out_data | lane_data[i];
    end

    assign busy      = (state == LOCK);
    assign fire      = busy & ~rst & (|avail_v) & ~out_almost_full;
    assign out_wr_en = fire;
    assign tail      = out_data[TAIL_BIT];

    // first eligible input at or after rr_ptr, wrapping modulo NUM_IN
    always_comb begin
        win_oh    = '0;
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = wrap_add(rr_ptr, k);
            if (!win_found && elig[cand]) begin
                win_oh[cand] = 1'b1;
                win_idx      = cand;
                win_found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            g_idx  <= '0;
        end else begin
            case (state)
                IDLE: if (win_found) begin
                    state <= LOCK;
                    grant <= win_oh;
                    g_idx <= win_idx;
                end
                LOCK: if (fire && tail) begin
                    state  <= IDLE;
                    grant  <= '0;
                    rr_ptr <= wrap_add(g_idx, 1);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (fire && flit_cnt != 16'hFFFF) flit_cnt <= flit_cnt + 16'd1;
            if (busy && !fire && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// Per-input slice: eligibility, pop strobe and grant-masked head flit.
module fb_output_arbiter_lane #(
    parameter int DATA_W = 8
) (
    input  logic              gnt,
    input  logic              req,
    input  logic              empty,
    input  logic              fire,
    input  logic [0:DATA_W-1] data,
    output logic              elig,
    output logic              avail,
    output logic              rd_en,
    output logic [0:DATA_W-1] data_sel
);
    assign elig     = req & ~empty;
    assign avail    = gnt & ~empty;
    assign rd_en    = gnt & fire;
    assign data_sel = gnt ? data : '0;
endmodule
